// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus arbiter: FSM states,
// HD44780 init commands and the CGRAM/DDRAM address bases.
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_XFER
   } lcd_state_t;

   localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
   localparam logic [7:0] LCD_CLEAR      = 8'h01;
   localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
   localparam logic [7:0] LCD_ENTRY      = 8'h06;
   localparam logic [7:0] LCD_CGRAM_BASE = 8'h40;
   localparam logic [7:0] LCD_DDRAM_BASE = 8'h80;

   localparam logic [1:0] INIT_LAST_IDX  = 2'd3;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = LCD_FUNC_SET;
         2'd1:    init_cmd = LCD_CLEAR;
         2'd2:    init_cmd = LCD_DISP_ON;
         default: init_cmd = LCD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// Free-running bus-slot counter with a registered enable window.
// start forces the next count to 0; en_allow gates the window (off in PWRUP/IDLE).
module lcd_slot_timer #(
   parameter int SLOT_CYCLES = 270000,
   parameter int EN_RISE     = 67500,
   parameter int EN_FALL     = 202500
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic en_allow,
   output logic last,
   output logic en
);

   localparam int CW = $clog2(SLOT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] RISE_CNT = CW'(EN_RISE);
   localparam logic [CW-1:0] FALL_CNT = CW'(EN_FALL);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          en_reg;
   logic          en_next;

   always_comb begin
      count_next = (start || (count_reg == LAST_CNT)) ? '0 : count_reg + 1'b1;
      // Window is decoded from the next count so en lines up with the count it belongs to
      en_next    = en_allow && (count_next >= RISE_CNT) && (count_next < FALL_CNT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
         en_reg    <= 1'b0;
      end else begin
         count_reg <= count_next;
         en_reg    <= en_next;
      end
   end

   assign last = (count_reg == LAST_CNT);
   assign en   = en_reg;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// HD44780 bus owner: power-up wait, four-command init, then round-robin
// byte writes from two requesters, one fixed-length slot per write.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int SLOT_CYCLES = 270000,
   parameter int EN_RISE     = 67500,
   parameter int EN_FALL     = 202500,
   parameter int PWRUP_SLOTS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       rs0,
   input  logic       rs1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int PW = $clog2(PWRUP_SLOTS + 1);
   localparam logic [PW-1:0] PWRUP_LAST = PW'(PWRUP_SLOTS - 1);

   lcd_state_t    state_reg, state_next;
   logic          ptr_reg, ptr_next;
   logic [PW-1:0] pwr_cnt_reg, pwr_cnt_next;
   logic [1:0]    init_idx_reg, init_idx_next;
   logic          ack0_reg, ack0_next;
   logic          ack1_reg, ack1_next;
   logic          busy_reg, busy_next;
   logic          init_done_reg, init_done_next;
   logic          lcd_rs_reg, lcd_rs_next;
   logic [7:0]    lcd_data_reg, lcd_data_next;

   logic slot_last;
   logic slot_en;
   logic grant;
   logic winner;
   logic init_final;

   assign init_final = slot_last && (init_idx_reg == INIT_LAST_IDX);
   // Pointer only matters on contention; a lone requester always wins
   assign winner     = (req0 && req1) ? ptr_reg : req1;

   always_comb begin
      grant = 1'b0;
      case (state_reg)
         ST_IDLE: grant = req0 || req1;
         ST_INIT: grant = init_final && (req0 || req1);
         ST_XFER: grant = slot_last && (req0 || req1);
         default: grant = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= ST_PWRUP;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_PWRUP: if (slot_last && (pwr_cnt_reg == PWRUP_LAST)) state_next = ST_INIT;
         ST_INIT:  if (init_final) state_next = grant ? ST_XFER : ST_IDLE;
         ST_IDLE:  if (grant) state_next = ST_XFER;
         ST_XFER:  if (slot_last) state_next = grant ? ST_XFER : ST_IDLE;
         default:  state_next = ST_PWRUP;
      endcase
   end

   always_comb begin
      ptr_next       = ptr_reg;
      pwr_cnt_next   = pwr_cnt_reg;
      init_idx_next  = init_idx_reg;
      ack0_next      = 1'b0;
      ack1_next      = 1'b0;
      init_done_next = init_done_reg;
      lcd_rs_next    = lcd_rs_reg;
      lcd_data_next  = lcd_data_reg;
      busy_next      = (state_next != ST_IDLE);
      case (state_reg)
         ST_PWRUP: begin
            if (slot_last) pwr_cnt_next = pwr_cnt_reg + 1'b1;
            if (state_next == ST_INIT) begin
               lcd_rs_next   = 1'b0;
               lcd_data_next = init_cmd(2'd0);
            end
         end
         ST_INIT: begin
            if (init_final) begin
               init_done_next = 1'b1;
            end else if (slot_last) begin
               init_idx_next = init_idx_reg + 2'd1;
               lcd_rs_next   = 1'b0;
               lcd_data_next = init_cmd(init_idx_reg + 2'd1);
            end
         end
         default: ;
      endcase
      if (grant) begin
         ack0_next     = !winner;
         ack1_next     = winner;
         lcd_rs_next   = winner ? rs1 : rs0;
         lcd_data_next = winner ? data1 : data0;
         ptr_next      = !winner;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_reg       <= 1'b0;
         pwr_cnt_reg   <= '0;
         init_idx_reg  <= 2'd0;
         ack0_reg      <= 1'b0;
         ack1_reg      <= 1'b0;
         busy_reg      <= 1'b1;
         init_done_reg <= 1'b0;
         lcd_rs_reg    <= 1'b0;
         lcd_data_reg  <= 8'h00;
      end else begin
         ptr_reg       <= ptr_next;
         pwr_cnt_reg   <= pwr_cnt_next;
         init_idx_reg  <= init_idx_next;
         ack0_reg      <= ack0_next;
         ack1_reg      <= ack1_next;
         busy_reg      <= busy_next;
         init_done_reg <= init_done_next;
         lcd_rs_reg    <= lcd_rs_next;
         lcd_data_reg  <= lcd_data_next;
      end
   end

   lcd_slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .EN_RISE     (EN_RISE),
      .EN_FALL     (EN_FALL)
   ) u_slot_timer (
      .clk      (clk),
      .reset    (reset),
      .start    (grant),
      .en_allow ((state_next == ST_INIT) || (state_next == ST_XFER)),
      .last     (slot_last),
      .en       (slot_en)
   );

   assign ack0      = ack0_reg;
   assign ack1      = ack1_reg;
   assign busy      = busy_reg;
   assign init_done = init_done_reg;
   assign lcd_rs    = lcd_rs_reg;
   assign lcd_rw    = 1'b0;
   assign lcd_en    = slot_en;
   assign lcd_data  = lcd_data_reg;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter with short slots (S=8, rise 2, fall 6, P=3).
// Expected acks and enable windows are queued at stimulus time and popped by a monitor.
module tb_lcd_bus_arbiter;
   import lcd_pkg::*;

   localparam int S  = 8;
   localparam int ER = 2;
   localparam int EF = 6;
   localparam int P  = 3;

   typedef struct {
      int id;
      int cyc;
   } ack_t;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         cyc;
   } en_t;

   logic       clk;
   logic       reset;
   logic       req0, req1, rs0, rs1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, busy, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   ack_t ack_q[$];
   en_t  en_q[$];
   en_t  e_cur;
   logic en_prev   = 1'b0;
   logic slot_open = 1'b0;

   lcd_bus_arbiter #(
      .SLOT_CYCLES (S),
      .EN_RISE     (ER),
      .EN_FALL     (EF),
      .PWRUP_SLOTS (P)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .rs0       (rs0),
      .rs1       (rs1),
      .data0     (data0),
      .data1     (data1),
      .ack0      (ack0),
      .ack1      (ack1),
      .busy      (busy),
      .init_done (init_done),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en),
      .lcd_data  (lcd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc seen at a negedge equals the cycle number of the following edge
   always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic push_ack(input int id, input int c);
      ack_t a;
      a.id  = id;
      a.cyc = c;
      ack_q.push_back(a);
   endtask

   task automatic push_en(input logic rs, input logic [7:0] d, input int c);
      en_t e;
      e.rs   = rs;
      e.data = d;
      e.cyc  = c;
      en_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Wait for n acks on requester id, presenting base+k for the k-th write
   task automatic serve(input int id, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         int   budget;
         logic seen;
         budget = 0;
         seen   = 1'b0;
         while (!seen && budget < 100) begin
            @(negedge clk);
            budget++;
            seen = (id == 0) ? ack0 : ack1;
         end
         check_val($sformatf("ack%0d_wait", id), seen, 1'b1);
         if (k < n - 1) begin
            if (id == 0) data0 = base + 8'(k + 1);
            else         data1 = base + 8'(k + 1);
         end else begin
            if (id == 0) req0 = 1'b0;
            else         req1 = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_lcd_en", lcd_en, 1'b0);
      check_val("rst_lcd_rs", lcd_rs, 1'b0);
      check_val("rst_lcd_data", lcd_data, 8'h00);
      check_val("rst_acks", {ack1, ack0}, 2'b00);
      check_val("rst_init_done", init_done, 1'b0);
      check_val("rst_busy", busy, 1'b1);
      check_val("leftover_acks", ack_q.size(), 0);
      check_val("leftover_slots", en_q.size(), 0);
      ack_q.delete();
      en_q.delete();
      push_en(1'b0, LCD_FUNC_SET, P*S + 0*S + ER);
      push_en(1'b0, LCD_CLEAR,    P*S + 1*S + ER);
      push_en(1'b0, LCD_DISP_ON,  P*S + 2*S + ER);
      push_en(1'b0, LCD_ENTRY,    P*S + 3*S + ER);
      reset = 1'b1;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (ack0 || ack1) begin
            if (ack_q.size() == 0) begin
               check_val("ack_unexpected", {ack1, ack0}, 2'b00);
            end else begin
               check_val("ack_id", {ack1, ack0}, (ack_q[0].id == 1) ? 2'b10 : 2'b01);
               check_val("ack_cycle", cyc, ack_q[0].cyc);
               ack_q.delete(0);
            end
         end
         if (lcd_en && !en_prev) begin
            if (en_q.size() == 0) begin
               check_val("en_unexpected", lcd_en, 1'b0);
            end else begin
               check_val("en_rise_cycle", cyc, en_q[0].cyc);
               check_val("slot_rs", lcd_rs, en_q[0].rs);
               check_val("slot_data", lcd_data, en_q[0].data);
               check_val("slot_rw", lcd_rw, 1'b0);
               e_cur     <= en_q[0];
               slot_open <= 1'b1;
               en_q.delete(0);
            end
         end
         if (!lcd_en && en_prev && slot_open) begin
            check_val("en_fall_cycle", cyc, e_cur.cyc + (EF - ER));
            check_val("slot_data_held", lcd_data, e_cur.data);
            slot_open <= 1'b0;
         end
      end else begin
         slot_open <= 1'b0;
      end
      en_prev <= lcd_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: reached cyc %0d without finishing", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      rs0   = 1'b0;
      rs1   = 1'b0;
      data0 = 8'h00;
      data1 = 8'h00;
      @(negedge clk);

      // init sequence, then a single data write
      do_reset();
      wait_cyc(55);
      check_val("init_done_pre", init_done, 1'b0);
      check_val("busy_in_init", busy, 1'b1);
      wait_cyc(56);
      check_val("init_done_rise", init_done, 1'b1);
      check_val("busy_idle", busy, 1'b0);
      wait_cyc(60);
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
      push_ack(0, 61);
      push_en(1'b1, 8'h41, 63);
      serve(0, 1, 8'h41);
      wait_cyc(68);
      check_val("busy_slot_end", busy, 1'b1);
      wait_cyc(69);
      check_val("busy_after", busy, 1'b0);
      check_val("idle_hold_data", lcd_data, 8'h41);
      check_val("idle_hold_rs", lcd_rs, 1'b1);

      // contention, then a second contention to show the pointer returned to 0
      do_reset();
      wait_cyc(60);
      req0 = 1'b1; rs0 = 1'b0; data0 = LCD_DDRAM_BASE;
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
      push_ack(0, 61); push_ack(1, 69);
      push_en(1'b0, LCD_DDRAM_BASE, 63); push_en(1'b1, 8'h42, 71);
      fork
         serve(0, 1, LCD_DDRAM_BASE);
         serve(1, 1, 8'h42);
      join
      wait_cyc(80);
      req0 = 1'b1; rs0 = 1'b0; data0 = 8'h81;
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h44;
      push_ack(0, 81); push_ack(1, 89);
      push_en(1'b0, 8'h81, 83); push_en(1'b1, 8'h44, 91);
      fork
         serve(0, 1, 8'h81);
         serve(1, 1, 8'h44);
      join
      wait_cyc(100);

      // request pending from before init_done, then fairness run
      do_reset();
      wait_cyc(10);
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h43;
      push_ack(1, 56);
      push_en(1'b1, 8'h43, 58);
      serve(1, 1, 8'h43);
      wait_cyc(70);
      req0 = 1'b1; rs0 = 1'b0; data0 = LCD_CGRAM_BASE;
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h60;
      for (int k = 0; k < 3; k++) begin
         push_ack(0, 71 + 16*k);
         push_ack(1, 79 + 16*k);
         push_en(1'b0, LCD_CGRAM_BASE + 8'(k), 73 + 16*k);
         push_en(1'b1, 8'h60 + 8'(k), 81 + 16*k);
      end
      fork
         serve(0, 3, LCD_CGRAM_BASE);
         serve(1, 3, 8'h60);
      join
      wait_cyc(125);

      // reset in the middle of a write slot, then full restart
      do_reset();
      wait_cyc(60);
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
      push_ack(0, 61);
      push_en(1'b1, 8'h5A, 63);
      wait_cyc(64);
      check_val("midslot_en_high", lcd_en, 1'b1);
      reset = 1'b0;
      req0  = 1'b0;
      @(negedge clk);
      check_val("midrst_lcd_en", lcd_en, 1'b0);
      check_val("midrst_lcd_data", lcd_data, 8'h00);
      check_val("midrst_init_done", init_done, 1'b0);
      do_reset();
      wait_cyc(55);
      check_val("reinit_done_pre", init_done, 1'b0);
      wait_cyc(56);
      check_val("reinit_done", init_done, 1'b1);
      wait_cyc(60);
      check_val("final_acks_left", ack_q.size(), 0);
      check_val("final_slots_left", en_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
